// File: rtl/aes_bram_pkg.sv
// Shared types and constants for the AES data-BRAM responder.
// Holds the FSM encoding, requester ids and the address legality rule.
package aes_bram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_RD_WAIT = 2'd2,
      ST_RESP    = 2'd3
   } aes_bram_state_e;

   localparam logic REQ_ENGINE = 1'b0;
   localparam logic REQ_HOST   = 1'b1;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 3;

   localparam logic [31:0] ERR_RDATA = 32'h0;

   // Range check is done on the full 32-bit offset, before truncation to the BRAM index.
   function automatic logic addr_illegal(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int          addr_w);
      logic [31:0] off;
      off = addr - base;
      return (addr[1:0] != 2'b00) || (addr < base) || ((off >> (addr_w + 2)) != 32'd0);
   endfunction

endpackage

// File: rtl/aes_bram_req_tracker.sv
// Per-requester release tracker: once served, a requester must drop its
// request line(s) before it becomes eligible again.
module aes_bram_req_tracker (
   input  logic aes_clk,
   input  logic aes_rst,
   input  logic req,
   input  logic done,
   output logic eligible
);

   logic served;

   // A line already low at its own completion edge needs no further release.
   always_ff @(posedge aes_clk or posedge aes_rst) begin
      if (aes_rst) begin
         served <= 1'b0;
      end else if (done) begin
         served <= req;
      end else if (!req) begin
         served <= 1'b0;
      end
   end

   assign eligible = req & ~served;

endmodule

// File: rtl/aes_bram_responder.sv
// Memory-side responder: arbitrates AES engine and host word accesses onto a
// single-port BRAM and returns a one-cycle completion per request.
module aes_bram_responder
   import aes_bram_pkg::*;
#(
   parameter int          ADDR_W       = 12,
   parameter int          READ_LATENCY = 2,
   parameter logic [31:0] BASE_ADDR    = 32'h0
) (
   input  logic              aes_clk,
   input  logic              aes_rst,
   input  logic              aes_start_read,
   input  logic              aes_start_write,
   input  logic [31:0]       aes_bram_addr,
   input  logic [31:0]       aes_bram_write_data,
   output logic [31:0]       aes_bram_read_data,
   output logic              bram_complete,
   output logic              bram_err,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [31:0]       host_addr,
   input  logic [31:0]       host_wdata,
   output logic [31:0]       host_rdata,
   output logic              host_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_din,
   input  logic [31:0]       mem_dout,
   output logic [1:0]        dbg_state
);

   if (READ_LATENCY < RD_LAT_MIN || READ_LATENCY > RD_LAT_MAX) begin : g_bad_latency
      $error("aes_bram_responder: READ_LATENCY must be in 1..3");
   end

   localparam logic [1:0] RD_LAST = 2'(READ_LATENCY - 1);

   aes_bram_state_e   state_q, state_d;
   logic              gnt_q, last_q, we_q, err_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q, rd_q, eng_rd_q;
   logic [1:0]        cnt_q;

   logic              eng_req, eng_elig, host_elig, eng_done, host_done;
   logic              grant_valid, grant_id, req_we, req_illegal;
   logic [31:0]       req_addr, req_wdata;
   logic [ADDR_W-1:0] req_word;
   logic              resp, rd_last, eng_rd_upd;

   assign eng_req = aes_start_read | aes_start_write;

   aes_bram_req_tracker u_eng_trk (
      .aes_clk  (aes_clk),
      .aes_rst  (aes_rst),
      .req      (eng_req),
      .done     (eng_done),
      .eligible (eng_elig)
   );

   aes_bram_req_tracker u_host_trk (
      .aes_clk  (aes_clk),
      .aes_rst  (aes_rst),
      .req      (host_req),
      .done     (host_done),
      .eligible (host_elig)
   );

   // Arbitration and request selection: alternate on contention.
   always_comb begin
      grant_valid = eng_elig | host_elig;
      if (eng_elig && host_elig) begin
         grant_id = ~last_q;
      end else if (eng_elig) begin
         grant_id = REQ_ENGINE;
      end else begin
         grant_id = REQ_HOST;
      end
      if (grant_id == REQ_ENGINE) begin
         req_addr    = aes_bram_addr;
         req_wdata   = aes_bram_write_data;
         req_we      = aes_start_write;
         req_illegal = addr_illegal(aes_bram_addr, BASE_ADDR, ADDR_W)
                       | (aes_start_read & aes_start_write);
      end else begin
         req_addr    = host_addr;
         req_wdata   = host_wdata;
         req_we      = host_we;
         req_illegal = addr_illegal(host_addr, BASE_ADDR, ADDR_W);
      end
      req_word = ADDR_W'((req_addr - BASE_ADDR) >> 2);
   end

   // Illegal requests still spend their ISSUE cycle, without strobing the BRAM,
   // so every non-read completion lands two cycles after acceptance.
   always_comb begin
      state_d = state_q;
      mem_en  = 1'b0;
      mem_we  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (grant_valid) begin
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (err_q) begin
               state_d = ST_RESP;
            end else begin
               mem_en  = 1'b1;
               mem_we  = we_q;
               state_d = we_q ? ST_RESP : ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            if (cnt_q == RD_LAST) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign resp       = (state_q == ST_RESP);
   assign rd_last    = (state_q == ST_RD_WAIT) && (cnt_q == RD_LAST);
   assign eng_done   = resp && (gnt_q == REQ_ENGINE);
   assign host_done  = resp && (gnt_q == REQ_HOST);
   assign eng_rd_upd = eng_done && (!we_q || err_q);

   always_ff @(posedge aes_clk or posedge aes_rst) begin
      if (aes_rst) begin
         state_q  <= ST_IDLE;
         gnt_q    <= REQ_ENGINE;
         last_q   <= REQ_HOST;
         we_q     <= 1'b0;
         err_q    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= 32'h0;
         rd_q     <= 32'h0;
         eng_rd_q <= 32'h0;
         cnt_q    <= 2'd0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && grant_valid) begin
            gnt_q   <= grant_id;
            last_q  <= grant_id;
            we_q    <= req_we;
            err_q   <= req_illegal;
            addr_q  <= req_word;
            wdata_q <= req_wdata;
            rd_q    <= ERR_RDATA;
         end
         if (state_q == ST_ISSUE) begin
            cnt_q <= 2'd0;
         end else if (state_q == ST_RD_WAIT) begin
            cnt_q <= cnt_q + 2'd1;
         end
         if (rd_last) begin
            rd_q <= mem_dout;
         end
         if (eng_rd_upd) begin
            eng_rd_q <= rd_q;
         end
      end
   end

   assign mem_addr           = addr_q;
   assign mem_din            = wdata_q;
   assign bram_complete      = eng_done;
   assign bram_err           = eng_done && err_q;
   assign host_ack           = host_done;
   assign host_rdata         = host_done ? rd_q : 32'h0;
   assign aes_bram_read_data = eng_rd_upd ? rd_q : eng_rd_q;
   assign dbg_state          = state_q;

endmodule
